// File: rtl/led_pulse_stretcher_pkg.sv
// Shared state encoding for the LED / display driver family.
package led_pulse_stretcher_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } led_state_e;

endpackage

// File: rtl/led_pulse_stretcher_cycle_timer.sv
// Loadable down-counter that parks at zero; zero flag comes straight from the register.
module cycle_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed on/off LED blinks, queueing overlapping events.
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 4,
    parameter int unsigned OFF_CYCLES = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_in,
    input  logic              ovf_clr,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam logic [CNT_W-1:0]  ON_LOAD   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    led_state_e        state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              pend_inc, pend_dec;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_load_val;
    logic [CNT_W-1:0]  tmr_value;
    logic              tmr_zero;

    cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        pend_inc     = 1'b0;
        pend_dec     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (p_in) begin
                    state_d      = ST_ON;
                    tmr_load     = 1'b1;
                    tmr_load_val = ON_LOAD;
                end
            end
            ST_ON: begin
                pend_inc = p_in;
                if (tmr_zero) begin
                    state_d      = ST_GAP;
                    tmr_load     = 1'b1;
                    tmr_load_val = OFF_LOAD;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    // A fresh pulse at gap exit either starts the blink directly
                    // (empty queue) or replaces the queued event being consumed.
                    if (pend_q != '0) begin
                        state_d      = ST_ON;
                        tmr_load     = 1'b1;
                        tmr_load_val = ON_LOAD;
                        pend_dec     = 1'b1;
                        pend_inc     = p_in;
                    end else if (p_in) begin
                        state_d      = ST_ON;
                        tmr_load     = 1'b1;
                        tmr_load_val = ON_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    pend_inc = p_in;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (pend_inc && !pend_dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (pend_dec && !pend_inc) begin
            pend_d = pend_q - 1'b1;
        end
        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign pending = pend_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench: directed scenarios plus random pulses against a blink-position model.
module tb_led_pulse_stretcher;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int PW  = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_in;
    logic          ovf_clr;
    logic          led_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    // Model: position inside the current ON+OFF period (-1 when idle).
    int m_pos  = -1;
    int m_pend = 0;
    bit m_ovf  = 1'b0;

    led_pulse_stretcher #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .CNT_W      (32),
        .PEND_W     (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .p_in    (p_in),
        .ovf_clr (ovf_clr),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (got running, need finished)");
        $fatal(1);
    end

    task automatic model_reset();
        m_pos  = -1;
        m_pend = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic c);
        bit enq;
        bit set_ovf;
        enq = 1'b0;
        set_ovf = 1'b0;
        if (m_pos < 0) begin
            if (p) m_pos = 0;
        end else if (m_pos == ON + OFF - 1) begin
            if (m_pend > 0) begin
                m_pos  = 0;
                m_pend = m_pend - 1;
                enq    = p;
            end else if (p) begin
                m_pos = 0;
            end else begin
                m_pos = -1;
            end
        end else begin
            m_pos = m_pos + 1;
            enq   = p;
        end
        if (enq) begin
            if (m_pend == PMAX) set_ovf = 1'b1;
            else m_pend = m_pend + 1;
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge with outputs settled.
    task automatic step(input logic p, input logic c);
        p_in    = p;
        ovf_clr = c;
        @(posedge clk);
        model_edge(p, c);
        @(negedge clk);
        p_in    = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || m_pos >= 0) && n < 60) begin
            step(1'b0, 1'b0);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || m_pos >= 0) begin
            failures++;
            $display("FAIL drain: busy=%0b model_pos=%0d after %0d cycles, need idle", busy, m_pos, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            p_in = (i % 2 == 0);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({led_out, busy, pending, ovf} !== '0) begin
                failures++;
                $display("FAIL reset_hold: led=%0b busy=%0b pending=%0d ovf=%0b, need all 0",
                         led_out, busy, pending, ovf);
            end
        end
        p_in = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (led_out !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_release: led=%0b busy=%0b, need 0 0", led_out, busy);
            end
        end
    endtask

    task automatic test_single();
        step(1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (led_out !== (j < ON) || busy !== (j < ON + OFF)) begin
                failures++;
                $display("FAIL single_blink[%0d]: led=%0b busy=%0b, need %0b %0b",
                         j, led_out, busy, (j < ON), (j < ON + OFF));
            end
            step(1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int max_p;
        int starts;
        logic prev;
        max_p  = 0;
        starts = 0;
        prev   = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step((e == 0 || e == 2 || e == 3), 1'b0);
            if (int'(pending) > max_p) max_p = int'(pending);
            if (led_out && !prev) begin
                checks++;
                if (!(e == 0 || e == 6 || e == 12)) begin
                    failures++;
                    $display("FAIL b2b_start: blink started at cycle %0d, need 1, 7 or 13", e + 1);
                end
                starts++;
            end
            prev = led_out;
            checks++;
            if (led_out !== (m_pos >= 0 && m_pos < ON) || pending !== PW'(m_pend)) begin
                failures++;
                $display("FAIL b2b_cycle[%0d]: led=%0b pending=%0d, need %0b %0d",
                         e + 1, led_out, pending, (m_pos >= 0 && m_pos < ON), m_pend);
            end
            if (e == 12) begin
                checks++;
                if (pending !== '0) begin
                    failures++;
                    $display("FAIL b2b_pend_empty: pending=%0d at third start, need 0", pending);
                end
            end
        end
        checks++;
        if (max_p != 2 || starts != 3) begin
            failures++;
            $display("FAIL b2b_summary: peak pending=%0d blinks=%0d, need 2 3", max_p, starts);
        end
    endtask

    task automatic test_saturation();
        int blinks;
        int n;
        logic prev;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        checks++;
        if (pending !== PW'(PMAX) || ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_state: pending=%0d ovf=%0b, need %0d 1", pending, ovf, PMAX);
        end
        blinks = 1;
        prev   = led_out;
        n      = 0;
        while ((busy || m_pos >= 0) && n < 80) begin
            step(1'b0, 1'b0);
            if (led_out && !prev) blinks++;
            prev = led_out;
            n++;
        end
        checks++;
        if (blinks != 4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sat_blinks: blinks=%0d busy=%0b, need 4 0", blinks, busy);
        end
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_sticky: ovf=%0b, need 1", ovf);
        end
        step(1'b0, 1'b1);
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear: ovf=%0b, need 0", ovf);
        end
    endtask

    task automatic test_gap_exit_pulse();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        checks++;
        if (led_out !== 1'b0 || busy !== 1'b1 || pending !== PW'(1)) begin
            failures++;
            $display("FAIL gap_last: led=%0b busy=%0b pending=%0d, need 0 1 1", led_out, busy, pending);
        end
        step(1'b1, 1'b0);
        checks++;
        if (led_out !== 1'b1 || pending !== PW'(1)) begin
            failures++;
            $display("FAIL gap_exit: led=%0b pending=%0d, need 1 1", led_out, pending);
        end
        drain();
    endtask

    task automatic test_reset_mid_blink();
        int on_cnt;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({led_out, busy, pending, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_async: led=%0b busy=%0b pending=%0d ovf=%0b, need all 0",
                     led_out, busy, pending, ovf);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0);
        on_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (led_out) on_cnt++;
            step(1'b0, 1'b0);
        end
        checks++;
        if (on_cnt != ON || pending !== '0) begin
            failures++;
            $display("FAIL reset_recover: on cycles=%0d pending=%0d, need %0d 0", on_cnt, pending, ON);
        end
    endtask

    task automatic test_random();
        logic p;
        logic c;
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 99) < 35);
            c = ($urandom_range(0, 99) < 4);
            step(p, c);
            checks++;
            if (led_out !== (m_pos >= 0 && m_pos < ON) || busy !== (m_pos >= 0)) begin
                failures++;
                $display("FAIL rand_led[%0d]: led=%0b busy=%0b, need %0b %0b",
                         i, led_out, busy, (m_pos >= 0 && m_pos < ON), (m_pos >= 0));
            end
            checks++;
            if (pending !== PW'(m_pend) || ovf !== m_ovf) begin
                failures++;
                $display("FAIL rand_pend[%0d]: pending=%0d ovf=%0b, need %0d %0b",
                         i, pending, ovf, m_pend, m_ovf);
            end
        end
        drain();
    endtask

    initial begin
        rst     = 1'b0;
        p_in    = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_gap_exit_pulse();
        test_reset_mid_blink();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
